// File: rtl/data_sram_responder.sv
// data_sram_responder: responder side of the data SRAM interface.
// Word-organised synchronous RAM with byte-lane writes, registered read
// data, configurable wait states (stall_req) and out-of-range flagging.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   data_sram_en     access request valid
//   data_sram_wen    byte write enables (4'b0000 = read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered read data
//   stall_req        combinational hold request while an access is pending
//   addr_err         one-cycle pulse after an out-of-range completion
module data_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req,
  output logic        addr_err
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  complete;

  // Address decode relative to the base; wrap-around below base is out of range.
  assign off      = data_sram_addr - BASE_ADDR;
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = off[DEPTH_LOG2+1:2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: count presented cycles; drop back to IDLE on completion or abort.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (stall_req) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'd1;
        end
      end
      BUSY: begin
        if (stall_req) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs: stall while waiting; an access completes when presented and not stalled.
  always_comb begin
    stall_req = 1'b0;
    if (WAIT_CYCLES != 0) begin
      if (state == IDLE) stall_req = data_sram_en;
      else               stall_req = data_sram_en && (cnt < WAIT_N);
    end
    complete = data_sram_en && !stall_req && !rst;
  end

  // Registered read data and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= 32'd0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= complete && !in_range;
      if (complete) begin
        if (!in_range)                 data_sram_rdata <= 32'd0;
        else if (data_sram_wen == 4'd0) data_sram_rdata <= mem[idx];
      end
    end
  end

  // Array is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (complete && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) driven in
// turn with directed and random accesses against a transaction-level model.
module tb_data_sram_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        en    [NI];
  logic [3:0]  wen   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        stall [NI];
  logic        aerr  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_rd  [NI];
  logic        exp_err [NI];
  logic [31:0] mm [int];

  always #5 clk = ~clk;

  data_sram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .stall_req(stall[0]), .addr_err(aerr[0]));

  data_sram_responder #(.BASE_ADDR(32'h0000_0400), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .stall_req(stall[1]), .addr_err(aerr[1]));

  data_sram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
    .stall_req(stall[2]), .addr_err(aerr[2]));

  function automatic int wait_of(int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] base_of(int k);
    return (k == 1) ? 32'h0000_0400 : 32'h0000_0000;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(int k, logic exp_stall);
    check($sformatf("u%0d rdata", k), rdata[k], exp_rd[k]);
    check($sformatf("u%0d addr_err", k), 32'(aerr[k]), 32'(exp_err[k]));
    check($sformatf("u%0d stall_req", k), 32'(stall[k]), 32'(exp_stall));
  endtask

  // Model of one completed access: 4 KiB window above the base.
  task automatic model_complete(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    logic [31:0] off;
    logic [31:0] word;
    int key;
    off = a - base_of(k);
    if (off >= 32'h1000) begin
      exp_rd[k]  = 32'd0;
      exp_err[k] = 1'b1;
    end else begin
      exp_err[k] = 1'b0;
      key = k * 1024 + int'(off / 4);
      word = mm.exists(key) ? mm[key] : 32'd0;
      if (w == 4'd0) begin
        exp_rd[k] = word;
      end else begin
        for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
        mm[key] = word;
      end
    end
  endtask

  // Present a request held stable until completion; called at a falling edge.
  task automatic access(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    int nw;
    nw = wait_of(k);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    for (int n = 0; n <= nw; n++) begin
      #1;
      check_outs(k, n < nw);
      @(negedge clk);
      if (n == nw) model_complete(k, w, a, d);
      else         exp_err[k] = 1'b0;
    end
  endtask

  // Idle cycles with garbage on the ignored inputs.
  task automatic idle(int k, int c);
    en[k] = 1'b0; wen[k] = 4'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
    repeat (c) begin
      #1;
      check_outs(k, 1'b0);
      @(negedge clk);
      exp_err[k] = 1'b0;
    end
  endtask

  task automatic expect_rd(int k, string tag, logic [31:0] v);
    #1;
    check(tag, rdata[k], v);
  endtask

  task automatic expect_err(int k, string tag, logic v);
    #1;
    check(tag, 32'(aerr[k]), 32'(v));
  endtask

  task automatic random_phase(int k, int count);
    int unsigned r;
    logic [31:0] a;
    logic [3:0]  w;
    for (int t = 0; t < count; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = base_of(k) + 32'h1000 + 32'($urandom_range(0, 4095));
      else if (r == 1) a = base_of(k) - 32'd4;
      else             a = base_of(k) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      access(k, w, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle(k, int'($urandom_range(1, 2)));
    end
    idle(k, 1);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
      exp_rd[k] = 32'd0; exp_err[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    for (int k = 0; k < NI; k++) idle(k, 1);

    // Fill the first 16 words of each instance so every later read is defined.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) access(k, 4'hF, base_of(k) + 32'(i * 4), $urandom);
      idle(k, 1);
    end

    // Zero wait states: write/read, byte lane merge, out-of-range.
    access(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    access(0, 4'h0, 32'h10, 32'h0);
    expect_rd(0, "t1 read-after-write", 32'hDEAD_BEEF);
    access(0, 4'b0010, 32'h12, 32'h0000_AA00);
    access(0, 4'h0, 32'h10, 32'h0);
    expect_rd(0, "t2 byte lane", 32'hDEAD_AAEF);
    access(0, 4'hF, 32'h0, 32'h1111_1111);
    access(0, 4'hF, 32'h1000, 32'h1234_5678);
    expect_err(0, "t4 oor write err", 1'b1);
    expect_rd(0, "t4 oor write rdata", 32'h0);
    access(0, 4'h0, 32'h1000, 32'h0);
    expect_err(0, "t4 oor read err", 1'b1);
    access(0, 4'h0, 32'h0, 32'h0);
    expect_err(0, "t4 err cleared", 1'b0);
    idle(0, 1);
    expect_rd(0, "t4 word0 intact", 32'h1111_1111);

    // Three wait states: back-to-back reads each see a fresh stall count.
    access(2, 4'h0, 32'h10, 32'h0);
    access(2, 4'h0, 32'h14, 32'h0);
    idle(2, 1);

    // Reset while BUSY (cnt=2) drops the pending write.
    access(2, 4'hF, 32'h20, 32'hCAFE_F00D);
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'h0BAD_BEEF;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_outs(2, 1'b1);
      if (n == 2) rst[2] = 1'b1;
      @(negedge clk);
      exp_err[2] = 1'b0;
    end
    rst[2] = 1'b0;
    exp_rd[2] = 32'd0;
    expect_rd(2, "t5 rdata after reset", 32'h0);
    access(2, 4'h0, 32'h20, 32'h0);
    expect_rd(2, "t5 write dropped", 32'hCAFE_F00D);
    idle(2, 1);

    // Two wait states: abort a write while BUSY.
    access(1, 4'hF, 32'h408, 32'h600D_F00D);
    access(1, 4'h0, 32'h408, 32'h0);
    en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h408; wdata[1] = 32'h0BAD_0BAD;
    for (int n = 0; n < 2; n++) begin
      #1;
      check_outs(1, 1'b1);
      @(negedge clk);
      exp_err[1] = 1'b0;
    end
    idle(1, 2);
    expect_rd(1, "t6 rdata held", 32'h600D_F00D);
    access(1, 4'h0, 32'h408, 32'h0);
    expect_rd(1, "t6 no write", 32'h600D_F00D);
    idle(1, 1);

    for (int k = 0; k < NI; k++) random_phase(k, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
